if_pll_reconfig_ctrl: RTL and testbench
=======================================

IF_PLL_RECONFIG_CTRL -- requirements
Module: if_pll_reconfig_ctrl

Interface
REQ-001 SHALL have parameter N_DIV, default 1: PLL pre-divider value applied on every reconfiguration.
REQ-002 SHALL have parameter C0_DIV, default 4: PLL output divider value, matching the quadrature /4.
REQ-003 SHALL have parameter RST_CYCLES, default 4: number of cycles pll_reset is held high.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum wait for cfg_busy or pll_lock.
REQ-005 clk  in  1  single system clock; all logic runs on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 if_freq  in  9  requested IF code; the PLL M value.
REQ-008 freq_strobe  in  1  one-cycle request to apply if_freq.
REQ-009 pll_m, pll_n, pll_c0  out  9, 8, 8  counter values driven to the PLL reconfig port.
REQ-010 cfg_strobe  out  1  one-cycle pulse commanding the reconfig port to load values.
REQ-011 cfg_busy  in  1  high while the reconfig port is writing.
REQ-012 pll_reset  out  1  PLL reset.
REQ-013 pll_lock  in  1  raw PLL lock indicator.
REQ-014 locked  out  1  PLL is configured to the applied code and locked.
REQ-015 err  out  1  sticky: last request rejected or timed out.

Function
REQ-016 SHALL implement the states IDLE, LOAD, WAIT_BUSY, WAIT_DONE, RST_PLL and WAIT_LOCK.
REQ-017 IDLE + freq_strobe SHALL capture if_freq; next cycle SHALL enter LOAD.
REQ-018 LOAD SHALL register pll_m=code, pll_n=N_DIV, pll_c0=C0_DIV, pulse cfg_strobe for exactly 1 cycle, then go to WAIT_BUSY.
REQ-019 WAIT_BUSY SHALL go to WAIT_DONE on cfg_busy=1; WAIT_DONE SHALL go to RST_PLL on cfg_busy=0.
REQ-020 RST_PLL SHALL hold pll_reset=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-021 WAIT_LOCK SHALL go to IDLE on the first pll_lock=1, record the code as applied, and clear err.
REQ-022 locked SHALL equal (state==IDLE) AND applied-valid AND pll_lock; loss of lock in IDLE SHALL drop locked the same cycle without starting a reconfiguration.
REQ-023 locked SHALL be 0 in every non-IDLE state.
REQ-024 if_freq=0 at strobe SHALL be rejected: err=1, no cfg_strobe, stay IDLE, and the previous applied state SHALL be kept.
REQ-025 A strobe in IDLE with code equal to the applied code while locked=1 SHALL be ignored (no cfg_strobe).
REQ-026 A strobe outside IDLE SHALL be held in a one-deep pending slot; a newer strobe SHALL overwrite it; the pending request SHALL be serviced on the cycle IDLE is re-entered.
REQ-027 freq_strobe and a return to IDLE in the same cycle SHALL make the new strobe value win over the pending slot.

Reset
REQ-028 rst SHALL force: state IDLE, pll_m=0, pll_n=0, pll_c0=0, cfg_strobe=0, pll_reset=1, locked=0, err=0, pending cleared, applied-valid=0.
REQ-029 pll_reset SHALL deassert on the first clock after rst falls.
REQ-030 rst asserted mid-sequence SHALL abort immediately with no further cfg_strobe.

Configuration
REQ-031 With IF_PLL_TIMEOUT_EN defined, WAIT_BUSY, WAIT_DONE and WAIT_LOCK SHALL each count cycles; reaching TIMEOUT_CYCLES SHALL set err=1, leave applied-valid=0, and return to IDLE.
REQ-032 Without IF_PLL_TIMEOUT_EN, the wait states SHALL wait indefinitely and err SHALL be set only by REQ-024.

Structure
REQ-033 Package if_synth_pkg SHALL hold the state enum, FREQ_W=9, DIV_W=8 and the counter width constant.
REQ-034 Sub-module if_pll_timer SHALL be a loadable down-counter with a done flag, shared by RST_PLL and the timeouts.

Verification
REQ-035 rst, then strobe if_freq=100, busy high 3 cycles, lock after 10 cycles -> one cfg_strobe; pll_m=100, pll_n=1, pll_c0=4; pll_reset high 4 cycles; locked=1.
REQ-036 Strobe if_freq=0 -> err=1, no cfg_strobe, locked unchanged.
REQ-037 While locked at 100, strobe 100 -> no cfg_strobe; strobe 200 -> locked=0 and full sequence ends with pll_m=200.
REQ-038 Strobes 150 then 175 during WAIT_LOCK -> after the current lock, exactly one extra sequence runs, with pll_m=175.
REQ-039 IF_PLL_TIMEOUT_EN, TIMEOUT_CYCLES=16, pll_lock held 0 -> err=1 and IDLE after 16 cycles in WAIT_LOCK, locked=0.
REQ-040 pll_lock drops for 1 cycle in IDLE -> locked=0 that cycle and 1 after, no cfg_strobe.

Source files
------------

// File: rtl/if_synth_pkg.sv
// if_synth_pkg: shared types and widths for the IF PLL reconfiguration controller.
package if_synth_pkg;
  localparam int FREQ_W = 9;
  localparam int DIV_W  = 8;
  localparam int CNT_W  = 16;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE, RST_PLL, WAIT_LOCK} state_t;
endpackage

// File: rtl/if_pll_timer.sv
// if_pll_timer: loadable down-counter; done is high once the count reaches zero.
module if_pll_timer
  import if_synth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] val,
  output logic             done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - CNT_W'(1);
  assign done = cnt == '0;
endmodule

// File: rtl/if_pll_reconfig_ctrl.sv
// if_pll_reconfig_ctrl: sequences PLL reconfiguration (load, reset, relock) per requested IF code.
// Define IF_PLL_TIMEOUT_EN to bound the busy/lock waits by TIMEOUT_CYCLES.
module if_pll_reconfig_ctrl
  import if_synth_pkg::*;
#(
  parameter int N_DIV          = 1,
  parameter int C0_DIV         = 4,
  parameter int RST_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FREQ_W-1:0] if_freq,
  input  logic              freq_strobe,
  output logic [FREQ_W-1:0] pll_m,
  output logic [DIV_W-1:0]  pll_n,
  output logic [DIV_W-1:0]  pll_c0,
  output logic              cfg_strobe,
  input  logic              cfg_busy,
  output logic              pll_reset,
  input  logic              pll_lock,
  output logic              locked,
  output logic              err
);
  state_t state, nxt;
  logic [FREQ_W-1:0] code, app_code, pend_code, req_code;
  logic app_v, pend_v, req_v, acc, rej, lock_ok, abort;
  logic t_load, t_done, tmo;
  logic [CNT_W-1:0] t_val;
  assign req_v    = freq_strobe | pend_v;
  assign req_code = freq_strobe ? if_freq : pend_code;
  assign locked   = state == IDLE && app_v && pll_lock;
  assign rej      = state == IDLE && req_v && req_code == '0;
  assign acc      = state == IDLE && req_v && req_code != '0 && !(locked && req_code == app_code);
  assign lock_ok  = state == WAIT_LOCK && pll_lock;
  assign abort    = state != IDLE && nxt == IDLE && !lock_ok;
`ifdef IF_PLL_TIMEOUT_EN
  assign tmo = t_done;
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = acc ? LOAD : IDLE;
      LOAD:      nxt = WAIT_BUSY;
      WAIT_BUSY: nxt = cfg_busy ? WAIT_DONE : tmo ? IDLE : WAIT_BUSY;
      WAIT_DONE: nxt = !cfg_busy ? RST_PLL : tmo ? IDLE : WAIT_DONE;
      RST_PLL:   nxt = t_done ? WAIT_LOCK : RST_PLL;
      WAIT_LOCK: nxt = (pll_lock || tmo) ? IDLE : WAIT_LOCK;
      default:   nxt = IDLE;
    endcase
  end
  // One timer serves both the reset pulse width and the wait-state timeouts.
  assign t_load = nxt != state && nxt inside {WAIT_BUSY, WAIT_DONE, RST_PLL, WAIT_LOCK};
  assign t_val  = nxt == RST_PLL ? CNT_W'(RST_CYCLES - 1) : CNT_W'(TIMEOUT_CYCLES - 1);
  if_pll_timer u_timer (.clk(clk), .rst(rst), .load(t_load), .val(t_val), .done(t_done));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pll_m      <= '0;
      pll_n      <= '0;
      pll_c0     <= '0;
      cfg_strobe <= 1'b0;
      pll_reset  <= 1'b1;
      err        <= 1'b0;
      code       <= '0;
      app_code   <= '0;
      app_v      <= 1'b0;
      pend_code  <= '0;
      pend_v     <= 1'b0;
    end else begin
      state      <= nxt;
      cfg_strobe <= state == LOAD;
      pll_reset  <= nxt == RST_PLL;
      if (acc) begin
        code  <= req_code;
        app_v <= 1'b0;
      end
      if (state == LOAD) begin
        pll_m  <= code;
        pll_n  <= DIV_W'(N_DIV);
        pll_c0 <= DIV_W'(C0_DIV);
      end
      if (rej || abort) err <= 1'b1;
      if (lock_ok) begin
        app_v    <= 1'b1;
        app_code <= code;
        err      <= 1'b0;
      end
      // Requests arriving mid-sequence wait here; only the newest survives.
      if (state == IDLE) pend_v <= 1'b0;
      else if (freq_strobe) begin
        pend_v    <= 1'b1;
        pend_code <= if_freq;
      end
    end
  end
endmodule

// File: tb/tb_if_pll_reconfig_ctrl.sv
// tb_if_pll_reconfig_ctrl: directed vectors plus multi-cycle corner sequences for the PLL reconfig controller.
module tb_if_pll_reconfig_ctrl;
  logic clk = 0, rst = 1, freq_strobe = 0, cfg_busy, pll_lock;
  logic [8:0] if_freq = '0, pll_m;
  logic [7:0] pll_n, pll_c0;
  logic cfg_strobe, pll_reset, locked, err;
  logic hold_low = 0, glitch = 0;
  int ncmp = 0, nfail = 0, nstb = 0, nbad = 0, run = 0, last_run = 0;

  if_pll_reconfig_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .if_freq(if_freq), .freq_strobe(freq_strobe),
    .pll_m(pll_m), .pll_n(pll_n), .pll_c0(pll_c0), .cfg_strobe(cfg_strobe),
    .cfg_busy(cfg_busy), .pll_reset(pll_reset), .pll_lock(pll_lock),
    .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  // Reconfig port and PLL model: busy 3 cycles per strobe, lock 10 cycles after reset ends.
  initial begin
    int bl, lc;
    bl = 0; lc = 10; cfg_busy = 0; pll_lock = 0;
    forever begin
      @(posedge clk); #1;
      if (cfg_strobe) begin nstb++; bl = 3; end
      cfg_busy = bl > 0;
      if (bl > 0) bl--;
      if (pll_reset) begin pll_lock = 0; lc = 10; end
      else if (hold_low) pll_lock = 0;
      else if (lc > 0) begin lc--; if (lc == 0) pll_lock = 1; end
      else pll_lock = !glitch;
      if (locked && (cfg_strobe || cfg_busy || pll_reset)) nbad++;
      if (pll_reset) run++;
      else if (run > 0) begin last_run = run; run = 0; end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [8:0] c);
    @(negedge clk); if_freq = c; freq_strobe = 1;
    @(negedge clk); freq_strobe = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sig(input int which, input logic val, input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if ((which == 0 ? pll_reset : which == 1 ? pll_lock : cfg_busy) == val) break;
      @(negedge clk);
    end
    if (i == 200) chk({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [8:0] code;
    int strobes;
    int m;
    int e;
    int lk;
  } vec_t;

  initial begin
    vec_t v[8];
    int s0;
    v[0] = '{9'd100, 1, 100, 0, 1};
    v[1] = '{9'd0,   0, 100, 1, 1};
    v[2] = '{9'd100, 0, 100, 1, 1};
    v[3] = '{9'd200, 1, 200, 0, 1};
    v[4] = '{9'd0,   0, 200, 1, 1};
    v[5] = '{9'd300, 1, 300, 0, 1};
    v[6] = '{9'd511, 1, 511, 0, 1};
    v[7] = '{9'd1,   1, 1,   0, 1};

    wait_cycles(3);
    chk("rst_pll_m", pll_m, 0);
    chk("rst_pll_n", pll_n, 0);
    chk("rst_pll_c0", pll_c0, 0);
    chk("rst_cfg_strobe", cfg_strobe, 0);
    chk("rst_pll_reset", pll_reset, 1);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    rst = 0;
    @(negedge clk);
    chk("pll_reset_release", pll_reset, 0);
    wait_cycles(20);
    chk("raw_lock_not_locked", locked, 0);

    for (int i = 0; i < 8; i++) begin
      s0 = nstb;
      strobe(v[i].code);
      wait_cycles(40);
      chk($sformatf("v%0d_strobes", i), nstb - s0, v[i].strobes);
      chk($sformatf("v%0d_pll_m", i), pll_m, v[i].m);
      chk($sformatf("v%0d_pll_n", i), pll_n, 1);
      chk($sformatf("v%0d_pll_c0", i), pll_c0, 4);
      chk($sformatf("v%0d_err", i), err, v[i].e);
      chk($sformatf("v%0d_locked", i), locked, v[i].lk);
    end
    chk("pll_reset_len", last_run, 4);
    chk("locked_outside_idle", nbad, 0);

    s0 = nstb;
    @(negedge clk); glitch = 1;
    @(negedge clk); glitch = 0;
    chk("glitch_locked_low", locked, 0);
    @(negedge clk);
    chk("glitch_locked_back", locked, 1);
    wait_cycles(10);
    chk("glitch_no_strobe", nstb - s0, 0);

    s0 = nstb;
    @(negedge clk); if_freq = 9'd200; freq_strobe = 1;
    @(negedge clk); freq_strobe = 0;
    chk("new_code_locked_drop", locked, 0);
    wait_cycles(40);
    chk("new_code_pll_m", pll_m, 200);
    chk("new_code_locked", locked, 1);

    s0 = nstb;
    strobe(9'd120);
    wait_sig(0, 1'b1, "b_rst_rise");
    wait_sig(0, 1'b0, "b_rst_fall");
    strobe(9'd150);
    strobe(9'd175);
    wait_cycles(80);
    chk("pending_strobes", nstb - s0, 2);
    chk("pending_pll_m", pll_m, 175);
    chk("pending_locked", locked, 1);

    s0 = nstb;
    strobe(9'd230);
    wait_sig(0, 1'b1, "d_rst_rise");
    wait_sig(0, 1'b0, "d_rst_fall");
    strobe(9'd150);
    wait_sig(1, 1'b1, "d_lock");
    if_freq = 9'd220; freq_strobe = 1;
    @(negedge clk); freq_strobe = 0;
    wait_cycles(60);
    chk("coincident_strobes", nstb - s0, 2);
    chk("coincident_pll_m", pll_m, 220);

    strobe(9'd250);
    wait_sig(2, 1'b1, "e_busy");
    rst = 1; #1;
    chk("abort_cfg_strobe", cfg_strobe, 0);
    chk("abort_pll_reset", pll_reset, 1);
    chk("abort_pll_m", pll_m, 0);
    chk("abort_locked", locked, 0);
    @(negedge clk); rst = 0;
    s0 = nstb;
    @(negedge clk);
    chk("abort_release", pll_reset, 0);
    wait_cycles(30);
    chk("abort_no_strobe", nstb - s0, 0);
    chk("abort_locked_after", locked, 0);

    hold_low = 1;
    strobe(9'd300);
    wait_sig(0, 1'b1, "f_rst_rise");
    wait_sig(0, 1'b0, "f_rst_fall");
`ifdef IF_PLL_TIMEOUT_EN
    begin
      int n;
      for (n = 0; n < 100 && !err; n++) @(negedge clk);
      chk("timeout_cycles", n, 16);
      chk("timeout_err", err, 1);
      hold_low = 0;
      wait_cycles(20);
      chk("timeout_locked", locked, 0);
    end
`else
    wait_cycles(60);
    chk("no_timeout_err", err, 0);
    chk("no_timeout_locked", locked, 0);
    hold_low = 0;
    wait_cycles(20);
    chk("no_timeout_lock_late", locked, 1);
    chk("no_timeout_pll_m", pll_m, 300);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
